// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared FSM encodings and sizing helpers for the sequential divider.
// The optional signed mode is enabled by defining SEQ_DIV_SIGNED_EN.
package seq_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Width of the step counter that runs 0..width-1; never narrower than one bit.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// seq_div_step: one combinational restoring-division step (the div_step stage).
// Shifts the next dividend bit into the partial remainder (with one guard bit)
// and subtracts the divisor when it fits, producing one quotient bit.
module seq_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_prem,
  input  logic [WIDTH-1:0] i_dvs,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_prem,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  // Shifted remainder keeps the guard bit so the compare never overflows.
  assign w_shift = {i_prem, i_bit};
  assign o_qbit  = (w_shift >= {1'b0, i_dvs});
  // When the divisor fits the difference is below the divisor, so WIDTH bits suffice.
  assign w_diff  = w_shift[WIDTH-1:0] - i_dvs;
  assign o_prem  = o_qbit ? w_diff : w_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring divider, one quotient bit per clock, with
// valid/ready handshakes on operand and result sides.
// Define SEQ_DIV_SIGNED_EN to add the SGN port and two's-complement mode.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter bit DBZ_QUOT_ONES = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             START,
  output logic             IN_RDY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VLD,
  input  logic             OUT_RDY,
  output logic [WIDTH-1:0] QUOT,
  output logic [WIDTH-1:0] REM,
  output logic             DBZ
`ifdef SEQ_DIV_SIGNED_EN
  ,
  input  logic             SGN
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_prem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic             w_b_zero;
  logic             w_last;
  logic [WIDTH-1:0] w_step_prem;
  logic             w_step_q;
  logic [WIDTH-1:0] w_quot_raw;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_dbz_quot;

  assign w_b_zero   = (B == {WIDTH{1'b0}});
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_dbz_quot = DBZ_QUOT_ONES ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  seq_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_prem (r_prem),
    .i_dvs  (r_dvs),
    .i_bit  (r_dvd[WIDTH-1]),
    .o_prem (w_step_prem),
    .o_qbit (w_step_q)
  );

  // Quotient bits shift in at the bottom as dividend bits leave the top.
  assign w_quot_raw = {r_dvd[WIDTH-2:0], w_step_q};

`ifdef SEQ_DIV_SIGNED_EN
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_a_neg    = SGN & A[WIDTH-1];
  assign w_b_neg    = SGN & B[WIDTH-1];
  // The most negative value maps to its own bit pattern, which is the correct unsigned magnitude.
  assign w_a_mag    = w_a_neg ? (~A + {{(WIDTH-1){1'b0}}, 1'b1}) : A;
  assign w_b_mag    = w_b_neg ? (~B + {{(WIDTH-1){1'b0}}, 1'b1}) : B;
  assign w_quot_fix = r_neg_q ? (~w_quot_raw + {{(WIDTH-1){1'b0}}, 1'b1}) : w_quot_raw;
  assign w_rem_fix  = r_neg_r ? (~w_step_prem + {{(WIDTH-1){1'b0}}, 1'b1}) : w_step_prem;

  // Result sign flags captured at accept so later SGN/A/B changes cannot disturb them.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (START && (r_state == S_IDLE)) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end else begin
      r_neg_q <= r_neg_q;
      r_neg_r <= r_neg_r;
    end
  end
`else
  assign w_a_mag    = A;
  assign w_b_mag    = B;
  assign w_quot_fix = w_quot_raw;
  assign w_rem_fix  = w_step_prem;
`endif

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: zero divisor skips the iteration entirely.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_next_state = w_b_zero ? S_DONE : S_CALC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_CALC;
        end
      end
      S_DONE: begin
        if (OUT_RDY) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    IN_RDY  = 1'b0;
    OUT_VLD = 1'b0;
    case (r_state)
      S_IDLE:  IN_RDY  = 1'b1;
      S_CALC:  IN_RDY  = 1'b0;
      S_DONE:  OUT_VLD = 1'b1;
      default: begin
        IN_RDY  = 1'b0;
        OUT_VLD = 1'b0;
      end
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_dvd  <= {WIDTH{1'b0}};
      r_dvs  <= {WIDTH{1'b0}};
      r_prem <= {WIDTH{1'b0}};
      r_quot <= {WIDTH{1'b0}};
      r_rem  <= {WIDTH{1'b0}};
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_dvd  <= w_a_mag;
            r_dvs  <= w_b_mag;
            r_prem <= {WIDTH{1'b0}};
            if (w_b_zero) begin
              r_quot <= w_dbz_quot;
              r_rem  <= A;
              r_dbz  <= 1'b1;
            end else begin
              r_dbz  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_CALC: begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_dvd  <= w_quot_raw;
          r_prem <= w_step_prem;
          if (w_last) begin
            r_quot <= w_quot_fix;
            r_rem  <= w_rem_fix;
          end else begin
            r_quot <= r_quot;
          end
        end
        S_DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign QUOT = r_quot;
  assign REM  = r_rem;
  assign DBZ  = r_dbz;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: scoreboard bench for seq_div (WIDTH=8). A second instance built
// with DBZ_QUOT_ONES=1 runs in lockstep to cover the all-ones quotient option.
// Signed vectors are added when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_div;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       d;
    logic [7:0] q1;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       d;
  } vec_t;

  logic       Clk;
  logic       Rst;
  logic       START;
  logic [7:0] A;
  logic [7:0] B;
  logic       sgn_v;
  logic       rand_rdy;
  logic       rdy_force;
  logic       rnd_rdy;
  wire        OUT_RDY;
  logic       IN_RDY, OUT_VLD, DBZ;
  logic [7:0] QUOT, REM;
  logic       IN_RDY1, OUT_VLD1, DBZ1;
  logic [7:0] QUOT1, REM1;

  int   n_checks;
  int   n_pass;
  exp_t sb[$];
  exp_t mon_e;

  assign OUT_RDY = rand_rdy ? rnd_rdy : rdy_force;

  seq_div #(.WIDTH(8), .DBZ_QUOT_ONES(1'b0)) dut (
    .Clk(Clk), .Rst(Rst), .START(START), .IN_RDY(IN_RDY), .A(A), .B(B),
    .OUT_VLD(OUT_VLD), .OUT_RDY(OUT_RDY), .QUOT(QUOT), .REM(REM), .DBZ(DBZ)
`ifdef SEQ_DIV_SIGNED_EN
    , .SGN(sgn_v)
`endif
  );

  seq_div #(.WIDTH(8), .DBZ_QUOT_ONES(1'b1)) dut_ones (
    .Clk(Clk), .Rst(Rst), .START(START), .IN_RDY(IN_RDY1), .A(A), .B(B),
    .OUT_VLD(OUT_VLD1), .OUT_RDY(OUT_RDY), .QUOT(QUOT1), .REM(REM1), .DBZ(DBZ1)
`ifdef SEQ_DIV_SIGNED_EN
    , .SGN(sgn_v)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Random consumer readiness, only used while rand_rdy is set.
  always @(posedge Clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 1) == 1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every retired result is compared against the oldest expectation.
  always @(negedge Clk) begin
    if (!Rst && OUT_VLD && OUT_RDY) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: QUOT=0x%0h REM=0x%0h with nothing pending", QUOT, REM);
      end else begin
        mon_e = sb.pop_front();
        check("quot", {24'd0, QUOT}, {24'd0, mon_e.q});
        check("rem", {24'd0, REM}, {24'd0, mon_e.r});
        check("dbz", {31'd0, DBZ}, {31'd0, mon_e.d});
        check("ones_vld", {31'd0, OUT_VLD1}, 32'd1);
        check("ones_quot", {24'd0, QUOT1}, {24'd0, mon_e.q1});
        check("ones_rem", {24'd0, REM1}, {24'd0, mon_e.r});
        check("ones_dbz", {31'd0, DBZ1}, {31'd0, mon_e.d});
      end
    end
  end

  function automatic exp_t mk(input logic [7:0] q, input logic [7:0] r, input logic d);
    exp_t e;
    e.q  = q;
    e.r  = r;
    e.d  = d;
    e.q1 = d ? 8'hFF : q;
    return e;
  endfunction

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s, input exp_t e);
    int n;
    n = 0;
    while (!IN_RDY && n < 200) begin
      @(posedge Clk);
      #1;
      n++;
    end
    if (!IN_RDY) begin
      n_checks++;
      $display("FAIL in_rdy_timeout: IN_RDY=%0b after %0d cycles, need 1", IN_RDY, n);
    end
    START = 1'b1;
    A     = a;
    B     = b;
    sgn_v = s;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    START = 1'b0;
    A     = 8'($urandom);
    B     = 8'($urandom);
    sgn_v = ~s;
  endtask

  task automatic latency(input string name, input logic [7:0] a, input logic [7:0] b,
                         input exp_t e, input int exp_lat);
    int n;
    issue(a, b, 1'b0, e);
    n = 1;
    while (!OUT_VLD && n < 40) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check(name, n, exp_lat);
    check("in_rdy_in_done", {31'd0, IN_RDY}, 32'd0);
  endtask

  task automatic wait_vld();
    int n;
    n = 0;
    while (!OUT_VLD && n < 40) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("vld_timeout", {31'd0, OUT_VLD}, 32'd1);
  endtask

  vec_t vecs[10];

  initial begin
    int   k;
    int   hits;
    logic [7:0] ra, rb;

    n_checks  = 0;
    n_pass    = 0;
    START     = 1'b0;
    A         = 8'd0;
    B         = 8'd0;
    sgn_v     = 1'b0;
    rand_rdy  = 1'b0;
    rdy_force = 1'b1;
    Rst       = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;

    check("rst_in_rdy", {31'd0, IN_RDY}, 32'd1);
    check("rst_out_vld", {31'd0, OUT_VLD}, 32'd0);
    check("rst_quot", {24'd0, QUOT}, 32'd0);
    check("rst_rem", {24'd0, REM}, 32'd0);
    check("rst_dbz", {31'd0, DBZ}, 32'd0);

    // Latency and basic results.
    latency("lat_100_7", 8'd100, 8'd7, mk(8'd14, 8'd2, 1'b0), 9);
    latency("lat_55_0", 8'd55, 8'd0, mk(8'd0, 8'd55, 1'b1), 1);
    @(posedge Clk);
    #1;

    // Directed vectors with hand-computed results.
    vecs[0] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   d: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   d: 1'b0};
    vecs[2] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,   d: 1'b0};
    vecs[3] = '{a: 8'd7,   b: 8'd9,   q: 8'd0,   r: 8'd7,   d: 1'b0};
    vecs[4] = '{a: 8'd200, b: 8'd16,  q: 8'd12,  r: 8'd8,   d: 1'b0};
    vecs[5] = '{a: 8'd129, b: 8'd2,   q: 8'd64,  r: 8'd1,   d: 1'b0};
    vecs[6] = '{a: 8'd254, b: 8'd3,   q: 8'd84,  r: 8'd2,   d: 1'b0};
    vecs[7] = '{a: 8'd0,   b: 8'd0,   q: 8'd0,   r: 8'd0,   d: 1'b1};
    vecs[8] = '{a: 8'd250, b: 8'd128, q: 8'd1,   r: 8'd122, d: 1'b0};
    vecs[9] = '{a: 8'd255, b: 8'd0,   q: 8'd0,   r: 8'd255, d: 1'b1};
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, 1'b0, mk(vecs[i].q, vecs[i].r, vecs[i].d));
    end

`ifdef SEQ_DIV_SIGNED_EN
    issue(8'h9C, 8'h07, 1'b1, mk(8'hF2, 8'hFE, 1'b0));
    issue(8'h64, 8'hF9, 1'b1, mk(8'hF2, 8'h02, 1'b0));
    issue(8'h80, 8'hFF, 1'b1, mk(8'h80, 8'h00, 1'b0));
    issue(8'h9C, 8'h00, 1'b1, mk(8'h00, 8'h9C, 1'b1));
`endif

    // Backpressure: result held, START ignored, IN_RDY returns after retirement.
    k = 0;
    while (!IN_RDY && k < 40) begin
      @(posedge Clk);
      #1;
      k++;
    end
    rdy_force = 1'b0;
    issue(8'd100, 8'd7, 1'b0, mk(8'd14, 8'd2, 1'b0));
    wait_vld();
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", {31'd0, OUT_VLD}, 32'd1);
      check("bp_quot", {24'd0, QUOT}, 32'd14);
      check("bp_rem", {24'd0, REM}, 32'd2);
      check("bp_in_rdy", {31'd0, IN_RDY}, 32'd0);
      START = 1'b1;
      A     = 8'd9;
      B     = 8'd3;
      @(posedge Clk);
      #1;
    end
    START     = 1'b0;
    rdy_force = 1'b1;
    @(negedge Clk);
    check("bp_in_rdy_done_rdy", {31'd0, IN_RDY}, 32'd0);
    @(posedge Clk);
    #1;
    check("bp_in_rdy_back", {31'd0, IN_RDY}, 32'd1);
    check("bp_vld_clear", {31'd0, OUT_VLD}, 32'd0);

    // Reset four cycles into CALC discards the operation.
    issue(8'd200, 8'd3, 1'b0, mk(8'd66, 8'd2, 1'b0));
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    sb.delete();
    check("mid_rst_in_rdy", {31'd0, IN_RDY}, 32'd1);
    check("mid_rst_vld", {31'd0, OUT_VLD}, 32'd0);
    check("mid_rst_quot", {24'd0, QUOT}, 32'd0);
    check("mid_rst_rem", {24'd0, REM}, 32'd0);
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge Clk);
      #1;
      if (OUT_VLD) hits++;
    end
    check("mid_rst_no_vld", hits, 0);

    // Random sweep against a / and % model with random consumer readiness.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      rb = (i % 10 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (rb == 8'd0) begin
        issue(ra, rb, 1'b0, mk(8'd0, ra, 1'b1));
      end else begin
        issue(ra, rb, 1'b0, mk(ra / rb, ra % rb, 1'b0));
      end
    end
    rand_rdy  = 1'b0;
    rdy_force = 1'b1;

    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge Clk);
      #1;
      k++;
    end
    check("drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
